// File: rtl/serial_parallel_align.sv
// Comma-aligned serial-to-parallel deserialiser: MSB first, one bit per clock, WIDTH-bit words.
// Latency: DATA_OUT/VALID/COMMA_DET register on the edge that samples a word's last bit.
// No backpressure: VALID is a one-cycle strobe, and words presented while nothing is listening are lost.
//
// Ports: CLK, RESET (sync, active-low), DATA_IN (serial bit) ->
//        DATA_OUT (last aligned word), VALID (1-cycle strobe), COMMA_DET (word == COMMA),
//        LOCKED (FSM in LOCKED), ERR_COUNT [7:0] (only with SP_ALIGN_ERRCNT_EN).
// Optional macro SP_ALIGN_ERRCNT_EN: saturating count of lock-loss and sync-fail events.
module serial_parallel_align #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
  parameter int unsigned      LOCK_COUNT = 2,
  parameter int unsigned      LOSS_WORDS = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             DATA_IN,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             VALID,
  output logic             COMMA_DET,
  output logic             LOCKED
`ifdef SP_ALIGN_ERRCNT_EN
  ,
  output logic [7:0]       ERR_COUNT
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam int KW = $clog2(LOCK_COUNT + 1);
  localparam int GW = (LOSS_WORDS > 0) ? $clog2(LOSS_WORDS + 1) : 1;

  localparam logic [CW-1:0] EOW_CNT  = CW'(WIDTH - 1);
  localparam logic [KW-1:0] LOCK_TGT = KW'(LOCK_COUNT);
  localparam logic [GW-1:0] LOSS_TGT = GW'(LOSS_WORDS);

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_SYNC = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  state_t           state, state_nxt;
  // Only the newest WIDTH-1 bits need storing; the oldest bit of the
  // next word image is shifted out by the time it would be read.
  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] nsr;
  logic [CW-1:0]    bit_cnt, bit_nxt;
  logic [KW-1:0]    comma_cnt, comma_nxt;
  logic [GW-1:0]    gap_cnt, gap_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             valid_nxt, cdet_nxt;
  logic             eow, is_comma;

  assign LOCKED = (state == ST_LOCK);

  always_comb begin
    nsr       = {sr, DATA_IN};
    eow       = (bit_cnt == EOW_CNT);
    is_comma  = (nsr == COMMA);
    state_nxt = state;
    bit_nxt   = eow ? '0 : bit_cnt + 1'b1;
    comma_nxt = comma_cnt;
    gap_nxt   = gap_cnt;
    data_nxt  = DATA_OUT;
    valid_nxt = 1'b0;
    cdet_nxt  = 1'b0;
    unique case (state)
      ST_HUNT: begin
        // Gap count must start from zero whenever lock is (re)entered.
        gap_nxt = '0;
        if (is_comma) begin
          // Comma's last bit is on this edge, so the next edge starts a word.
          bit_nxt   = '0;
          comma_nxt = KW'(1);
          state_nxt = (LOCK_COUNT == 1) ? ST_LOCK : ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (eow) begin
          if (is_comma) begin
            comma_nxt = comma_cnt + 1'b1;
            if (comma_nxt == LOCK_TGT) state_nxt = ST_LOCK;
          end else begin
            state_nxt = ST_HUNT;
          end
        end
      end
      ST_LOCK: begin
        if (eow) begin
          data_nxt  = nsr;
          valid_nxt = 1'b1;
          cdet_nxt  = is_comma;
          if (is_comma) begin
            gap_nxt = '0;
          end else begin
            gap_nxt = gap_cnt + 1'b1;
            if ((LOSS_WORDS != 0) && (gap_nxt == LOSS_TGT)) state_nxt = ST_HUNT;
          end
        end
      end
      default: state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= ST_HUNT;
      sr        <= '0;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      gap_cnt   <= '0;
      DATA_OUT  <= '0;
      VALID     <= 1'b0;
      COMMA_DET <= 1'b0;
    end else begin
      state     <= state_nxt;
      sr        <= nsr[WIDTH-2:0];
      bit_cnt   <= bit_nxt;
      comma_cnt <= comma_nxt;
      gap_cnt   <= gap_nxt;
      DATA_OUT  <= data_nxt;
      VALID     <= valid_nxt;
      COMMA_DET <= cdet_nxt;
    end
  end

`ifdef SP_ALIGN_ERRCNT_EN
  // Any departure from SYNC or LOCKED back to HUNT is an alignment error.
  logic err_evt;
  assign err_evt = (state != ST_HUNT) && (state_nxt == ST_HUNT);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ERR_COUNT <= '0;
    end else if (err_evt && (ERR_COUNT != 8'hFF)) begin
      ERR_COUNT <= ERR_COUNT + 8'd1;
    end
  end
`endif

endmodule
